// File: rtl/button_pkg.sv
// Shared types, default 50 MHz timing and a width helper for the pushbutton conditioning chain.
package button_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PRESS_CHK = 3'd1,
        HELD      = 3'd2,
        REPEAT    = 3'd3,
        REL_CHK   = 3'd4
    } btn_state_t;

    localparam int DEF_SYNC_STAGES       = 2;
    localparam int DEF_DEBOUNCE_CYCLES   = 1000000;
    localparam int DEF_LONG_PRESS_CYCLES = 50000000;
    localparam int DEF_REPEAT_CYCLES     = 10000000;
    localparam int DEF_CNT_WIDTH         = 26;

    // True when value is representable in an unsigned counter of the given width.
    function automatic bit cnt_fits(input longint value, input int width);
        return (value < (64'sd1 <<< width));
    endfunction

endpackage

// File: rtl/bit_sync.sv
// Multi-flop synchroniser for one asynchronous board input; cleared by the async reset.
module bit_sync #(
    parameter int STAGES = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic din,
    output logic dout
);

    logic [STAGES-1:0] sync_r;

    // shift the raw input through the flop chain
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_r <= {STAGES{1'b0}};
        end else begin
            sync_r <= {sync_r[STAGES-2:0], din};
        end
    end

    assign dout = sync_r[STAGES-1];

endmodule

// File: rtl/button_debounce.sv
// Pushbutton conditioner: synchroniser, debounce FSM and hold timer producing
// registered level, press/release/long-press/auto-repeat and step events.
module button_debounce
    import button_pkg::*;
#(
    parameter int SYNC_STAGES       = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES   = DEF_DEBOUNCE_CYCLES,
    parameter int LONG_PRESS_CYCLES = DEF_LONG_PRESS_CYCLES,
    parameter int REPEAT_CYCLES     = DEF_REPEAT_CYCLES,
    parameter int CNT_WIDTH         = DEF_CNT_WIDTH
) (
    input  logic clock,
    input  logic reset,
    input  logic button,
    output logic btn_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse,
    output logic repeat_pulse,
    output logic step_pulse
);

    if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 2 || REPEAT_CYCLES < 2 ||
        LONG_PRESS_CYCLES <= DEBOUNCE_CYCLES ||
        !cnt_fits(longint'(LONG_PRESS_CYCLES), CNT_WIDTH) ||
        !cnt_fits(longint'(REPEAT_CYCLES), CNT_WIDTH)) begin : g_param_check
        $error("button_debounce: illegal timing parameters or CNT_WIDTH too small");
    end

    localparam logic [CNT_WIDTH-1:0] CNT_ZERO  = CNT_WIDTH'(0);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] DEB_LAST  = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] LONG_LAST = CNT_WIDTH'(LONG_PRESS_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] REP_LAST  = CNT_WIDTH'(REPEAT_CYCLES - 1);

    logic                 btn_s;
    btn_state_t           state_r;
    btn_state_t           state_nxt_s;
    logic [CNT_WIDTH-1:0] deb_cnt_r;
    logic [CNT_WIDTH-1:0] deb_nxt_s;
    logic [CNT_WIDTH-1:0] hold_cnt_r;
    logic [CNT_WIDTH-1:0] hold_nxt_s;
    logic                 origin_r;      // 1: REL_CHK was entered from REPEAT
    logic                 origin_nxt_s;
    logic                 level_nxt_s;
    logic                 press_nxt_s;
    logic                 release_nxt_s;
    logic                 long_nxt_s;
    logic                 repeat_nxt_s;

    bit_sync #(.STAGES(SYNC_STAGES)) u_sync (
        .clock (clock),
        .reset (reset),
        .din   (button),
        .dout  (btn_s)
    );

    // next-state, counter and pulse decode; a terminal count wins over a release sample
    always_comb begin
        state_nxt_s   = state_r;
        deb_nxt_s     = deb_cnt_r;
        hold_nxt_s    = hold_cnt_r;
        origin_nxt_s  = origin_r;
        level_nxt_s   = btn_level;
        press_nxt_s   = 1'b0;
        release_nxt_s = 1'b0;
        long_nxt_s    = 1'b0;
        repeat_nxt_s  = 1'b0;
        case (state_r)
            IDLE: begin
                level_nxt_s = 1'b0;
                hold_nxt_s  = CNT_ZERO;
                if (btn_s) begin
                    state_nxt_s = PRESS_CHK;
                    deb_nxt_s   = CNT_ONE;
                end else begin
                    deb_nxt_s   = CNT_ZERO;
                end
            end
            PRESS_CHK: begin
                if (!btn_s) begin
                    state_nxt_s = IDLE;
                    deb_nxt_s   = CNT_ZERO;
                end else if (deb_cnt_r == DEB_LAST) begin
                    state_nxt_s = HELD;
                    press_nxt_s = 1'b1;
                    level_nxt_s = 1'b1;
                    hold_nxt_s  = CNT_ZERO;
                    deb_nxt_s   = CNT_ZERO;
                end else begin
                    deb_nxt_s   = deb_cnt_r + CNT_ONE;
                end
            end
            HELD: begin
                if (hold_cnt_r == LONG_LAST) begin
                    state_nxt_s = REPEAT;
                    long_nxt_s  = 1'b1;
                    hold_nxt_s  = CNT_ZERO;
                end else begin
                    hold_nxt_s  = hold_cnt_r + CNT_ONE;
                    if (!btn_s) begin
                        state_nxt_s  = REL_CHK;
                        origin_nxt_s = 1'b0;
                        deb_nxt_s    = CNT_ONE;
                    end else begin
                        deb_nxt_s    = CNT_ZERO;
                    end
                end
            end
            REPEAT: begin
                if (hold_cnt_r == REP_LAST) begin
                    repeat_nxt_s = 1'b1;
                    hold_nxt_s   = CNT_ZERO;
                end else begin
                    hold_nxt_s   = hold_cnt_r + CNT_ONE;
                    if (!btn_s) begin
                        state_nxt_s  = REL_CHK;
                        origin_nxt_s = 1'b1;
                        deb_nxt_s    = CNT_ONE;
                    end else begin
                        deb_nxt_s    = CNT_ZERO;
                    end
                end
            end
            REL_CHK: begin
                if (btn_s) begin
                    state_nxt_s = origin_r ? REPEAT : HELD;
                    deb_nxt_s   = CNT_ZERO;
                end else if (deb_cnt_r == DEB_LAST) begin
                    state_nxt_s   = IDLE;
                    release_nxt_s = 1'b1;
                    level_nxt_s   = 1'b0;
                    hold_nxt_s    = CNT_ZERO;
                    deb_nxt_s     = CNT_ZERO;
                end else begin
                    deb_nxt_s     = deb_cnt_r + CNT_ONE;
                end
            end
            default: begin
                state_nxt_s  = IDLE;
                deb_nxt_s    = CNT_ZERO;
                hold_nxt_s   = CNT_ZERO;
                origin_nxt_s = 1'b0;
                level_nxt_s  = 1'b0;
            end
        endcase
    end

    // state, counters and all outputs are registered
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r       <= IDLE;
            deb_cnt_r     <= CNT_ZERO;
            hold_cnt_r    <= CNT_ZERO;
            origin_r      <= 1'b0;
            btn_level     <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_pulse    <= 1'b0;
            repeat_pulse  <= 1'b0;
            step_pulse    <= 1'b0;
        end else begin
            state_r       <= state_nxt_s;
            deb_cnt_r     <= deb_nxt_s;
            hold_cnt_r    <= hold_nxt_s;
            origin_r      <= origin_nxt_s;
            btn_level     <= level_nxt_s;
            press_pulse   <= press_nxt_s;
            release_pulse <= release_nxt_s;
            long_pulse    <= long_nxt_s;
            repeat_pulse  <= repeat_nxt_s;
            step_pulse    <= press_nxt_s | repeat_nxt_s;
        end
    end

endmodule

// File: tb/tb_button_debounce.sv
// Scoreboard bench: directed scenarios plus random button traffic, checked cycle by cycle
// against a run-length / elapsed-hold-time reference model.
module tb_button_debounce;

    localparam int SYNC = 2;
    localparam int DEB  = 4;
    localparam int LONG = 20;
    localparam int REP  = 5;
    localparam int CW   = 6;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic button = 1'b0;
    logic btn_level, press_pulse, release_pulse, long_pulse, repeat_pulse, step_pulse;

    always #5 clock = ~clock;

    button_debounce #(
        .SYNC_STAGES       (SYNC),
        .DEBOUNCE_CYCLES   (DEB),
        .LONG_PRESS_CYCLES (LONG),
        .REPEAT_CYCLES     (REP),
        .CNT_WIDTH         (CW)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .button        (button),
        .btn_level     (btn_level),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .long_pulse    (long_pulse),
        .repeat_pulse  (repeat_pulse),
        .step_pulse    (step_pulse)
    );

    logic [5:0] exp_q[$];
    int  n_cmp   = 0;
    int  n_bad   = 0;
    int  cyc     = 0;
    bit  running = 1'b0;

    // Reference model: the button as seen after SYNC flops, the accepted level, the
    // length of the current run of samples disagreeing with that level, and the
    // number of clocks the hold has been counting since the press.
    bit  hist[SYNC];
    bit  m_level;
    int  m_run;
    int  m_elapsed;
    bit  m_press, m_rel, m_long, m_rep;
    bit  rst_now = 1'b1;

    function automatic void model_clear();
        foreach (hist[i]) hist[i] = 1'b0;
        m_level = 1'b0; m_run = 0; m_elapsed = 0;
        m_press = 1'b0; m_rel = 1'b0; m_long = 1'b0; m_rep = 1'b0;
    endfunction

    function automatic void model_edge();
        bit s;
        s = hist[SYNC-1];
        for (int i = SYNC - 1; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = button;
        m_press = 1'b0; m_rel = 1'b0; m_long = 1'b0; m_rep = 1'b0;
        if (!m_level) begin
            m_run = s ? m_run + 1 : 0;
            if (m_run == DEB) begin
                m_level = 1'b1; m_press = 1'b1; m_run = 0; m_elapsed = 0;
            end
        end else begin
            // hold time only advances while no release candidate is pending
            if (m_run == 0) begin
                m_elapsed++;
                if (m_elapsed == LONG) m_long = 1'b1;
                else if (m_elapsed > LONG && ((m_elapsed - LONG) % REP) == 0) m_rep = 1'b1;
            end
            if (m_long || m_rep) m_run = 0;
            else m_run = s ? 0 : m_run + 1;
            if (m_run == DEB) begin
                m_level = 1'b0; m_rel = 1'b1; m_run = 0;
            end
        end
    endfunction

    task automatic step(input bit btn, input bit rst);
        @(posedge clock);
        if (!rst_now) model_edge();
        #1;
        reset   = rst;
        button  = btn;
        rst_now = rst;
        if (rst) model_clear();
        exp_q.push_back({m_level, m_press, m_rel, m_long, m_rep, m_press | m_rep});
    endtask

    task automatic seg(input bit btn, input int n);
        repeat (n) step(btn, 1'b0);
    endtask

    // monitor: pops one expectation per cycle and compares on the falling edge
    initial begin
        logic [5:0] e;
        logic [5:0] got;
        forever begin
            @(negedge clock);
            if (running) begin
                cyc++;
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL scoreboard_empty cycle %0d: no expectation queued", cyc);
                end else begin
                    e   = exp_q.pop_front();
                    got = {btn_level, press_pulse, release_pulse, long_pulse, repeat_pulse, step_pulse};
                    if (got !== e) begin
                        n_bad++;
                        $display("FAIL outputs cycle %0d {lvl,prs,rel,lng,rep,stp}: got %b expected %b",
                                 cyc, got, e);
                    end
                end
            end
        end
    end

    initial begin
        bit btn;
        model_clear();
        running = 1'b1;
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        // clean short press
        seg(1'b0, 10); seg(1'b1, 10); seg(1'b0, 20);
        // bounce then stable press
        seg(1'b1, 1); seg(1'b0, 1); seg(1'b1, 1); seg(1'b0, 1);
        seg(1'b1, 15); seg(1'b0, 15);
        // long hold with repeats
        seg(1'b1, 90); seg(1'b0, 15);
        // 2-clock glitch while in HELD
        seg(1'b1, 12); seg(1'b0, 2); seg(1'b1, 40); seg(1'b0, 15);
        // reset mid-REPEAT with the button held
        seg(1'b1, 40);
        repeat (3) step(1'b1, 1'b1);
        seg(1'b1, 15); seg(1'b0, 15);
        // release shorter than debounce, then re-press
        seg(1'b1, 15); seg(1'b0, 3); seg(1'b1, 10); seg(1'b0, 15);
        // random traffic: mostly bounce-length segments with occasional long holds
        btn = 1'b0;
        for (int k = 0; k < 150; k++) begin
            btn = ~btn;
            if ($urandom_range(0, 3) == 0) seg(btn, $urandom_range(20, 90));
            else seg(btn, $urandom_range(1, 6));
            if ($urandom_range(0, 29) == 0) begin
                repeat ($urandom_range(1, 3)) step(btn, 1'b1);
            end
        end
        seg(1'b0, 20);
        @(negedge clock);
        #1;
        running = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
